// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with level, almost flags, sticky error flags and optional FWFT read port
module sync_fifo #(
  parameter int BITS  = 32,
  parameter int SIZE  = 16,
  parameter int AF_TH = SIZE - 2,
  parameter int AE_TH = 2,
  parameter int FWFT  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    p_clear,
  input  logic                    p_write_en,
  input  logic [BITS-1:0]         p_write_data,
  output logic                    p_write_full,
  output logic                    p_write_almost_full,
  input  logic                    p_read_en,
  output logic [BITS-1:0]         p_read_data,
  output logic                    p_read_empty,
  output logic                    p_read_almost_empty,
  output logic [$clog2(SIZE):0]   p_level,
  output logic                    p_overflow,
  output logic                    p_underflow
);
  localparam int AW = $clog2(SIZE);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF = PW'(AF_TH);
  localparam logic [PW-1:0] AE = PW'(AE_TH);

  if ((SIZE < 2) || ((SIZE & (SIZE - 1)) != 0)) begin : g_bad_size
    $fatal(1, "sync_fifo: SIZE must be a power of two and at least 2");
  end

  logic [BITS-1:0] mem [SIZE];
  logic [PW-1:0]   wptr, rptr, lvl;
  logic            ovf, udf, full, empty, wr_ok, rd_ok;

  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = wptr == rptr;
  assign wr_ok = p_write_en && !full && !p_clear;
  assign rd_ok = p_read_en && !empty && !p_clear;

  assign p_write_full        = full;
  assign p_read_empty        = empty;
  assign p_level             = lvl;
  assign p_write_almost_full = lvl >= AF;
  assign p_read_almost_empty = lvl <= AE;
  assign p_overflow          = ovf;
  assign p_underflow         = udf;

  // storage array, written only on accepted writes; never reset or cleared
  always_ff @(posedge clk)
    if (wr_ok) mem[wptr[AW-1:0]] <= p_write_data;

  // pointers, level and sticky error flags; clear wins over same-cycle traffic
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      lvl  <= '0;
      ovf  <= 1'b0;
      udf  <= 1'b0;
    end else if (p_clear) begin
      wptr <= '0;
      rptr <= '0;
      lvl  <= '0;
      ovf  <= 1'b0;
      udf  <= 1'b0;
    end else begin
      wptr <= wr_ok ? wptr + PW'(1) : wptr;
      rptr <= rd_ok ? rptr + PW'(1) : rptr;
      lvl  <= (wr_ok && !rd_ok) ? lvl + PW'(1) : (rd_ok && !wr_ok) ? lvl - PW'(1) : lvl;
      ovf  <= ovf | (p_write_en && full);
      udf  <= udf | (p_read_en && empty);
    end

  if (FWFT != 0) begin : g_fwft
    assign p_read_data = mem[rptr[AW-1:0]];
  end else begin : g_reg
    logic [BITS-1:0] rdata;
    // registered read port: loads the head entry only on an accepted read
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rdata <= '0;
      else if (rd_ok) rdata <= mem[rptr[AW-1:0]];
    assign p_read_data = rdata;
  end
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: scoreboard bench for sync_fifo in registered and first-word-fall-through modes
module tb_sync_fifo;
  logic        clk, rst_n;
  logic        p_clear, p_write_en, p_read_en;
  logic [31:0] p_write_data, p_read_data;
  logic        p_write_full, p_write_almost_full, p_read_empty, p_read_almost_empty;
  logic [4:0]  p_level;
  logic        p_overflow, p_underflow;

  logic        f_clear, f_write_en, f_read_en;
  logic [7:0]  f_write_data, f_read_data;
  logic        f_full, f_afull, f_empty, f_aempty;
  logic [2:0]  f_level;
  logic        f_ovf, f_udf;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] sb[$];
  logic        m_ovf = 1'b0;
  logic        m_udf = 1'b0;
  logic        racc;
  logic [31:0] exp_rd;

  sync_fifo dut (
    .clk(clk), .rst_n(rst_n), .p_clear(p_clear),
    .p_write_en(p_write_en), .p_write_data(p_write_data),
    .p_write_full(p_write_full), .p_write_almost_full(p_write_almost_full),
    .p_read_en(p_read_en), .p_read_data(p_read_data),
    .p_read_empty(p_read_empty), .p_read_almost_empty(p_read_almost_empty),
    .p_level(p_level), .p_overflow(p_overflow), .p_underflow(p_underflow)
  );

  sync_fifo #(.BITS(8), .SIZE(4), .FWFT(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .p_clear(f_clear),
    .p_write_en(f_write_en), .p_write_data(f_write_data),
    .p_write_full(f_full), .p_write_almost_full(f_afull),
    .p_read_en(f_read_en), .p_read_data(f_read_data),
    .p_read_empty(f_empty), .p_read_almost_empty(f_aempty),
    .p_level(f_level), .p_overflow(f_ovf), .p_underflow(f_udf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // one clock of stimulus on the default FIFO; the model decides acceptance and keeps the scoreboard
  task automatic drive(input logic clr, input logic we, input logic [31:0] wd, input logic re,
                       output logic ra, output logic [31:0] er);
    logic wa;
    p_clear = clr; p_write_en = we; p_write_data = wd; p_read_en = re;
    wa = we && (sb.size() < 16);
    ra = re && (sb.size() > 0);
    @(posedge clk); #1;
    p_clear = 1'b0; p_write_en = 1'b0; p_read_en = 1'b0;
    er = '0;
    if (clr) begin
      sb.delete(); m_ovf = 1'b0; m_udf = 1'b0; ra = 1'b0;
    end else begin
      if (we && !wa) m_ovf = 1'b1;
      if (re && !ra) m_udf = 1'b1;
      if (ra) er = sb.pop_front();
      if (wa) sb.push_back(wd);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; p_clear = 1'b0; p_write_en = 1'b1; p_write_data = 32'hDEAD_BEEF; p_read_en = 1'b0;
    f_clear = 1'b0; f_write_en = 1'b0; f_write_data = '0; f_read_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (p_read_empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %b want 1", p_read_empty); end
    n_checks++; if (p_write_full !== 1'b0) begin n_errors++; $display("FAIL reset_full: got %b want 0", p_write_full); end
    n_checks++; if (p_level !== 5'd0) begin n_errors++; $display("FAIL reset_level: got %0d want 0", p_level); end
    n_checks++; if (p_read_almost_empty !== 1'b1 || p_write_almost_full !== 1'b0) begin n_errors++; $display("FAIL reset_almost: got ae=%b af=%b want ae=1 af=0", p_read_almost_empty, p_write_almost_full); end
    n_checks++; if (p_overflow !== 1'b0 || p_underflow !== 1'b0) begin n_errors++; $display("FAIL reset_sticky: got ovf=%b udf=%b want 0 0", p_overflow, p_underflow); end
    n_checks++; if (p_read_data !== 32'd0) begin n_errors++; $display("FAIL reset_rdata: got %0h want 0", p_read_data); end
    p_write_en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (p_level !== 5'd0 || p_read_empty !== 1'b1) begin n_errors++; $display("FAIL reset_release: got level=%0d empty=%b want 0 1", p_level, p_read_empty); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 32'(i), 1'b0, racc, exp_rd);
      n_checks++; if (p_level !== 5'(i + 1)) begin n_errors++; $display("FAIL fill_level: got %0d want %0d", p_level, i + 1); end
      n_checks++; if (p_write_almost_full !== ((i + 1) >= 14)) begin n_errors++; $display("FAIL fill_af at level %0d: got %b want %b", i + 1, p_write_almost_full, (i + 1) >= 14); end
      n_checks++; if (p_read_almost_empty !== ((i + 1) <= 2)) begin n_errors++; $display("FAIL fill_ae at level %0d: got %b want %b", i + 1, p_read_almost_empty, (i + 1) <= 2); end
      n_checks++; if (p_read_empty !== 1'b0) begin n_errors++; $display("FAIL fill_empty: got %b want 0", p_read_empty); end
      n_checks++; if (p_write_full !== (i == 15)) begin n_errors++; $display("FAIL fill_full at level %0d: got %b want %b", i + 1, p_write_full, i == 15); end
    end
    drive(1'b0, 1'b1, 32'hFFFF, 1'b0, racc, exp_rd);
    n_checks++; if (p_overflow !== 1'b1 || p_level !== 5'd16) begin n_errors++; $display("FAIL overflow_write: got ovf=%b level=%0d want 1 16", p_overflow, p_level); end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1, racc, exp_rd);
      n_checks++; if (!racc || p_read_data !== exp_rd) begin n_errors++; $display("FAIL fill_read %0d: got %0h want %0h", i, p_read_data, exp_rd); end
    end
    n_checks++; if (p_read_empty !== 1'b1 || p_level !== 5'd0) begin n_errors++; $display("FAIL drain: got empty=%b level=%0d want 1 0", p_read_empty, p_level); end
    drive(1'b0, 1'b0, '0, 1'b0, racc, exp_rd);
    n_checks++; if (p_read_data !== 32'd15) begin n_errors++; $display("FAIL rdata_hold: got %0h want f", p_read_data); end
    n_checks++; if (p_overflow !== m_ovf) begin n_errors++; $display("FAIL overflow_sticky: got %b want %b", p_overflow, m_ovf); end
    drive(1'b1, 1'b0, '0, 1'b0, racc, exp_rd);
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 32'h100 + 32'(i), 1'b0, racc, exp_rd);
    drive(1'b0, 1'b1, 32'h999, 1'b1, racc, exp_rd);
    n_checks++; if (p_level !== 5'd15 || p_overflow !== 1'b1) begin n_errors++; $display("FAIL full_wr_rd: got level=%0d ovf=%b want 15 1", p_level, p_overflow); end
    n_checks++; if (p_read_data !== exp_rd) begin n_errors++; $display("FAIL full_wr_rd_data: got %0h want %0h", p_read_data, exp_rd); end
    drive(1'b1, 1'b0, '0, 1'b0, racc, exp_rd);
    drive(1'b0, 1'b1, 32'h777, 1'b1, racc, exp_rd);
    n_checks++; if (p_level !== 5'd1 || p_underflow !== 1'b1 || p_overflow !== 1'b0) begin n_errors++; $display("FAIL empty_wr_rd: got level=%0d udf=%b ovf=%b want 1 1 0", p_level, p_underflow, p_overflow); end
    drive(1'b0, 1'b0, '0, 1'b1, racc, exp_rd);
    n_checks++; if (p_read_data !== exp_rd || exp_rd !== 32'h777) begin n_errors++; $display("FAIL empty_wr_rd_data: got %0h want 777", p_read_data); end
    drive(1'b1, 1'b0, '0, 1'b0, racc, exp_rd);
  endtask

  task automatic test_wraparound();
    int wr_n = 0;
    int cyc = 0;
    logic we, re, lvl_bad = 1'b0;
    while ((wr_n < 48 || sb.size() > 0) && cyc < 2000) begin
      we = (wr_n < 48) && (sb.size() < 16) && ($urandom_range(0, 2) != 0);
      re = (sb.size() > 0) && ($urandom_range(0, 2) != 0);
      drive(1'b0, we, 32'h1000 + 32'(wr_n), re, racc, exp_rd);
      if (we) wr_n++;
      cyc++;
      if (racc) begin
        n_checks++; if (p_read_data !== exp_rd) begin n_errors++; $display("FAIL wrap_data: got %0h want %0h", p_read_data, exp_rd); end
      end
      if (p_level > 5'd16 || p_level !== 5'(sb.size())) lvl_bad = 1'b1;
    end
    n_checks++; if (cyc >= 2000) begin n_errors++; $display("FAIL wrap_timeout: got %0d cycles want < 2000", cyc); end
    n_checks++; if (lvl_bad) begin n_errors++; $display("FAIL wrap_level: got out-of-range or wrong level want model level"); end
    n_checks++; if (p_overflow !== 1'b0 || p_underflow !== 1'b0) begin n_errors++; $display("FAIL wrap_sticky: got ovf=%b udf=%b want 0 0", p_overflow, p_underflow); end
  endtask

  task automatic test_clear();
    drive(1'b0, 1'b0, '0, 1'b1, racc, exp_rd);
    n_checks++; if (p_underflow !== 1'b1) begin n_errors++; $display("FAIL underflow_read: got %b want 1", p_underflow); end
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 32'h500 + 32'(i), 1'b0, racc, exp_rd);
    n_checks++; if (p_level !== 5'd9) begin n_errors++; $display("FAIL clear_prefill: got %0d want 9", p_level); end
    drive(1'b1, 1'b1, 32'hBAD, 1'b0, racc, exp_rd);
    n_checks++; if (p_level !== 5'd0 || p_read_empty !== 1'b1) begin n_errors++; $display("FAIL clear_state: got level=%0d empty=%b want 0 1", p_level, p_read_empty); end
    n_checks++; if (p_overflow !== 1'b0 || p_underflow !== 1'b0) begin n_errors++; $display("FAIL clear_flags: got ovf=%b udf=%b want 0 0", p_overflow, p_underflow); end
    drive(1'b0, 1'b1, 32'h1234, 1'b0, racc, exp_rd);
    drive(1'b0, 1'b0, '0, 1'b1, racc, exp_rd);
    n_checks++; if (p_read_data !== exp_rd || exp_rd !== 32'h1234) begin n_errors++; $display("FAIL clear_newdata: got %0h want 1234", p_read_data); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 32'h40 + 32'(i), 1'b0, racc, exp_rd);
    drive(1'b0, 1'b0, '0, 1'b1, racc, exp_rd);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (p_level !== 5'd0 || p_read_empty !== 1'b1 || p_read_data !== 32'd0) begin n_errors++; $display("FAIL async_reset: got level=%0d empty=%b rdata=%0h want 0 1 0", p_level, p_read_empty, p_read_data); end
    sb.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 32'hCAFE, 1'b0, racc, exp_rd);
    drive(1'b0, 1'b0, '0, 1'b1, racc, exp_rd);
    n_checks++; if (p_read_data !== exp_rd || exp_rd !== 32'hCAFE || p_read_empty !== 1'b1) begin n_errors++; $display("FAIL post_reset_write: got %0h empty=%b want cafe 1", p_read_data, p_read_empty); end
  endtask

  task automatic test_fwft();
    logic [7:0] fq[$];
    n_checks++; if (f_empty !== 1'b1) begin n_errors++; $display("FAIL fwft_start_empty: got %b want 1", f_empty); end
    f_write_en = 1'b1; f_write_data = 8'hA5; fq.push_back(8'hA5);
    @(posedge clk); #1;
    f_write_en = 1'b0;
    n_checks++; if (f_empty !== 1'b0 || f_read_data !== fq[0]) begin n_errors++; $display("FAIL fwft_fallthrough: got empty=%b data=%0h want 0 %0h", f_empty, f_read_data, fq[0]); end
    f_write_en = 1'b1; f_write_data = 8'h3C; fq.push_back(8'h3C);
    f_read_en = 1'b1; void'(fq.pop_front());
    @(posedge clk); #1;
    f_write_en = 1'b0;
    n_checks++; if (f_read_data !== fq[0] || f_level !== 3'd1) begin n_errors++; $display("FAIL fwft_advance: got data=%0h level=%0d want %0h 1", f_read_data, f_level, fq[0]); end
    void'(fq.pop_front());
    @(posedge clk); #1;
    f_read_en = 1'b0;
    n_checks++; if (f_empty !== 1'b1 || f_udf !== 1'b0) begin n_errors++; $display("FAIL fwft_drain: got empty=%b udf=%b want 1 0", f_empty, f_udf); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_simultaneous();
    test_wraparound();
    test_clear();
    test_async_reset();
    test_fwft();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
